// File: rtl/fu_cfg_pkg.sv
// fu_cfg_pkg: shared types for the FU configuration sequencer.
//   fu_cfg_t     - per-FU control configuration record (23 bits, laid out
//                  exactly like bits [22:0] of a config word)
//   seq_state_e  - sequencer state enum
//   word_to_cfg  - maps the low 23 bits of a config word onto fu_cfg_t
package fu_cfg_pkg;

  localparam int unsigned DELAY_LSB  = 0;
  localparam int unsigned DELAY_W    = 16;
  localparam int unsigned FORK_LSB   = 16;
  localparam int unsigned FORK_W     = 6;
  localparam int unsigned IVALID_BIT = 22;
  localparam int unsigned CFG_W      = 23;

  typedef struct packed {
    logic                initial_valid;
    logic [FORK_W-1:0]   fork_mask;
    logic [DELAY_W-1:0]  delay_value;
  } fu_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RELEASE,
    ST_RUN
  } seq_state_e;

  function automatic fu_cfg_t word_to_cfg(input logic [CFG_W-1:0] w);
    fu_cfg_t c;
    c.initial_valid = w[IVALID_BIT];
    c.fork_mask     = w[FORK_LSB +: FORK_W];
    c.delay_value   = w[DELAY_LSB +: DELAY_W];
    return c;
  endfunction

endpackage

// File: rtl/fu_config_sequencer_checksum.sv
// fu_cfg_checksum: running XOR accumulator over accepted config words.
// Only instantiated when FU_CFG_CHECKSUM_EN is defined.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   i_clear       - zero the accumulator (priority over i_en)
//   i_en          - fold i_data into the accumulator
//   i_data        - 32-bit word
//   o_sum         - current XOR of all words folded since the last clear
module fu_cfg_checksum (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [31:0] i_data,
  output logic [31:0] o_sum
);

  logic [31:0] r_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum ^ i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/fu_config_sequencer.sv
// fu_config_sequencer: loads one 32-bit config word per FU controller from a
// valid/ready stream, holds the FU array in reset while loading, then
// releases it after RST_CYCLES cycles and pulses done_o.
// Optional feature macro: FU_CFG_CHECKSUM_EN (adds a trailing XOR checksum
// word checked in state CHECK; mismatch sets sticky error_o and returns to IDLE).
// Ports:
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   start_i                 - start a load (honoured in IDLE and RUN only)
//   cfg_data_i/valid/ready  - config word stream
//   initial_valid_o         - per-FU initial valid
//   delay_value_o           - per-FU 16-bit delay value
//   fork_mask_o             - per-FU 6-bit fork mask
//   fu_rst_no               - registered active-low reset to the FU array
//   busy_o, done_o, error_o - status to the top-level controller
module fu_config_sequencer
  import fu_cfg_pkg::*;
#(
  parameter int unsigned NUM_FUS    = 16,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  output logic [NUM_FUS-1:0]        initial_valid_o,
  output logic [NUM_FUS-1:0][15:0]  delay_value_o,
  output logic [NUM_FUS-1:0][5:0]   fork_mask_o,
  output logic                      fu_rst_no,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  localparam int unsigned IDX_W  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
  localparam int unsigned RCNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_FUS - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);

  seq_state_e         r_state;
  seq_state_e         w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [RCNT_W-1:0]  r_rcnt;
  fu_cfg_t            r_cfg [NUM_FUS];
  logic               r_fu_rst_n;
  logic               r_done;

  logic w_ready;
  logic w_busy;
  logic w_accept;
  logic w_load_accept;
  logic w_last_word;
  logic w_rel_done;
  logic w_start;

  assign w_accept      = cfg_valid_i & w_ready;
  assign w_load_accept = w_accept && (r_state == ST_LOAD);
  assign w_last_word   = w_load_accept && (r_idx == LAST_IDX);
  assign w_rel_done    = (r_state == ST_RELEASE) && (r_rcnt == RCNT_LAST);
  assign w_start       = start_i && ((r_state == ST_IDLE) || (r_state == ST_RUN));

`ifdef FU_CFG_CHECKSUM_EN
  logic [31:0] w_sum;
  logic        w_chk_accept;
  logic        w_chk_match;
  logic        r_error;

  fu_cfg_checksum u_checksum (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clear (w_start),
    .i_en    (w_load_accept),
    .i_data  (cfg_data_i),
    .o_sum   (w_sum)
  );

  assign w_chk_accept = w_accept && (r_state == ST_CHECK);
  assign w_chk_match  = (cfg_data_i == w_sum);
`else
  // Upper word bits carry no configuration when no checksum is compared.
  logic w_unused_hi;
  assign w_unused_hi = ^cfg_data_i[31:CFG_W];
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start_i) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_last_word) begin
`ifdef FU_CFG_CHECKSUM_EN
          w_next = ST_CHECK;
`else
          w_next = ST_RELEASE;
`endif
        end
      end
      ST_CHECK: begin
`ifdef FU_CFG_CHECKSUM_EN
        if (w_chk_accept) w_next = w_chk_match ? ST_RELEASE : ST_IDLE;
`else
        w_next = ST_IDLE;
`endif
      end
      ST_RELEASE: if (w_rel_done) w_next = ST_RUN;
      ST_RUN:     if (start_i) w_next = ST_LOAD;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    unique case (r_state)
      ST_LOAD, ST_CHECK: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
      ST_RELEASE: w_busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word index, release counter, config store, registered status.
  // fu_rst_no is computed from the next state so it changes on the same edge
  // as the state (rises with RUN, falls the cycle after start_i in RUN).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx      <= '0;
      r_rcnt     <= '0;
      r_fu_rst_n <= 1'b0;
      r_done     <= 1'b0;
      for (int unsigned i = 0; i < NUM_FUS; i++) begin
        r_cfg[i] <= '0;
      end
    end else begin
      if (w_start) begin
        r_idx <= '0;
      end else if (w_load_accept && !w_last_word) begin
        r_idx <= r_idx + 1'b1;
      end

      if ((r_state == ST_RELEASE) && !w_rel_done) begin
        r_rcnt <= r_rcnt + 1'b1;
      end else begin
        r_rcnt <= '0;
      end

      if (w_load_accept) begin
        r_cfg[r_idx] <= word_to_cfg(cfg_data_i[CFG_W-1:0]);
      end

      r_fu_rst_n <= (w_next == ST_RUN);
      r_done     <= w_rel_done;
    end
  end

`ifdef FU_CFG_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_error <= 1'b0;
    end else if (w_start) begin
      r_error <= 1'b0;
    end else if (w_chk_accept && !w_chk_match) begin
      r_error <= 1'b1;
    end
  end
  assign error_o = r_error;
`else
  assign error_o = 1'b0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_FUS; i++) begin
      initial_valid_o[i] = r_cfg[i].initial_valid;
      delay_value_o[i]   = r_cfg[i].delay_value;
      fork_mask_o[i]     = r_cfg[i].fork_mask;
    end
  end

  assign cfg_ready_o = w_ready;
  assign busy_o      = w_busy;
  assign done_o      = r_done;
  assign fu_rst_no   = r_fu_rst_n;

endmodule

// File: tb/tb_fu_config_sequencer.sv
module tb_fu_config_sequencer;

  localparam int NF = 16;
  localparam int RC = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [31:0]          data;
  logic                 valid;
  logic                 ready;
  logic [NF-1:0]        iv;
  logic [NF-1:0][15:0]  dv;
  logic [NF-1:0][5:0]   fm;
  logic                 fu_rst_n;
  logic                 busy;
  logic                 done;
  logic                 err;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fu_config_sequencer #(.NUM_FUS(NF), .RST_CYCLES(RC)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .cfg_data_i      (data),
    .cfg_valid_i     (valid),
    .cfg_ready_o     (ready),
    .initial_valid_o (iv),
    .delay_value_o   (dv),
    .fork_mask_o     (fm),
    .fu_rst_no       (fu_rst_n),
    .busy_o          (busy),
    .done_o          (done),
    .error_o         (err)
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: words accepted so far, edges since the last word,
  // and whether the array has been released.
  logic [22:0] m_cfg [NF];
  bit m_loading, m_releasing, m_running, m_done;
  int m_idx, m_edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) m_cfg[i] = '0;
      m_loading = 0; m_releasing = 0; m_running = 0; m_done = 0;
      m_idx = 0; m_edges = 0;
    end else begin
      m_done = 0;
      if (m_loading) begin
        if (valid) begin
          m_cfg[m_idx] = data[22:0];
          if (m_idx == NF - 1) begin
            m_loading = 0; m_releasing = 1; m_edges = 0;
          end else begin
            m_idx++;
          end
        end
      end else if (m_releasing) begin
        m_edges++;
        if (m_edges == RC) begin
          m_releasing = 0; m_running = 1; m_done = 1;
        end
      end else if (start) begin
        m_loading = 1; m_running = 0; m_idx = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [NF-1:0]       e_iv;
    logic [NF-1:0][15:0] e_dv;
    logic [NF-1:0][5:0]  e_fm;
    for (int i = 0; i < NF; i++) begin
      e_iv[i] = m_cfg[i][22];
      e_fm[i] = m_cfg[i][21:16];
      e_dv[i] = m_cfg[i][15:0];
    end
    check("fu_rst_no", fu_rst_n, m_running);
    check("cfg_ready", ready, m_loading);
    check("busy", busy, m_loading | m_releasing);
    check("done", done, m_done);
    check("error", err, 1'b0);
    check("initial_valid", iv, e_iv);
    check("delay_value", dv, e_dv);
    check("fork_mask", fm, e_fm);
    if (done) done_cnt++;
  end

  task automatic realign();
    @(posedge clk); #2;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    realign();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    logic r;
    int n;
    valid = 1'b0;
    repeat (gap) realign();
    valid = 1'b1;
    data  = w;
    n = 0;
    forever begin
      @(negedge clk);
      r = ready;
      realign();
      if (r) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    valid = 1'b0;
  endtask

  task automatic load_range(input logic [31:0] base, input int first, input int gap);
    for (int i = first; i < NF; i++) send(base + 32'(i), gap);
  endtask

  // Counts edges after the last accepted word until fu_rst_no is seen high.
  task automatic wait_release();
    int n = 0;
    forever begin
      @(negedge clk);
      if (fu_rst_n) break;
      n++;
      if (n > 20) begin
        check("release_timeout", 1, 0);
        break;
      end
    end
    check("release_delay", n, RC);
    realign();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) realign();
    @(negedge clk);
    check("idle_rst", fu_rst_n, 0);
    check("idle_ready", ready, 0);
    check("idle_cfg", dv, 0);
    check("idle_done_cnt", done_cnt, 0);
    realign();

    // Back-to-back load
    start_pulse();
    load_range(32'h0040_0003, 0, 0);
    wait_release();
    check("l1_dv0", dv[0], 16'd3);
    check("l1_dv15", dv[15], 16'd18);
    check("l1_iv", iv, 16'hFFFF);
    check("l1_fm", fm, 0);
    check("l1_done_cnt", done_cnt, 1);

    // Restart from RUN, valid toggling every other cycle
    start_pulse();
    @(negedge clk);
    check("restart_rst_low", fu_rst_n, 0);
    realign();
    load_range(32'h0040_0003, 0, 1);
    wait_release();
    check("l2_dv7", dv[7], 16'd10);
    check("l2_iv", iv, 16'hFFFF);
    check("l2_done_cnt", done_cnt, 2);

    // Reset mid-load after word 7
    start_pulse();
    for (int i = 0; i < 8; i++) send(32'h0000_0100 + 32'(i), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_cfg", dv, 0);
    check("rst_iv", iv, 0);
    check("rst_ready", ready, 0);
    realign();
    rst_n = 1'b1;
    realign();
    start_pulse();
    load_range(32'hFFC0_0010, 0, 0);
    wait_release();
    check("l3_dv0", dv[0], 16'h0010);
    check("l3_iv", iv, 16'hFFFF);
    check("l3_fm3", fm[3], 0);
    check("l3_done_cnt", done_cnt, 3);

    // Reload FU0 with fork mask 0x3F; others hold old config until rewritten
    start_pulse();
    send(32'h007F_0003, 0);
    @(negedge clk);
    check("rl_fm0", fm[0], 6'h3F);
    check("rl_dv0", dv[0], 16'd3);
    check("rl_dv1_old", dv[1], 16'h0011);
    check("rl_rst_low", fu_rst_n, 0);
    realign();
    load_range(32'h0040_0003, 1, 0);
    wait_release();
    check("rl_fm0_final", fm[0], 6'h3F);
    check("rl_fm1_final", fm[1], 0);
    check("rl_dv1_final", dv[1], 16'd4);
    check("rl_done_cnt", done_cnt, 4);

    repeat (3) realign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
